// File: rtl/run_trigger_ctrl.sv
// Purpose : host-sequenced run-of-ones trigger; arms, detects cfg_len consecutive 1s on `in`,
//           pulses trig, waits a holdoff window, then re-arms or idles; saturating trigger count.
// Latency : trig is high the cycle after the edge that samples the len-th consecutive 1; all outputs registered.
// Backpressure: none; `in` is sampled every cycle and control pulses are acted on at the next edge.
//
// Ports:
//   clk, reset (sync, active-high)      : clock and reset
//   in                                  : monitored serial bit
//   arm / disarm / clr_count            : host control pulses (disarm beats arm)
//   cfg_len / cfg_rearm                 : run length (0 acts as 1) and continuous/single-shot, latched on arm
//   armed / busy / trig / run_cnt       : state flags, trigger pulse, current run length
//   trig_count / timeout                : saturating trigger total, armed-timeout pulse
// Optional feature macro: RUN_TRIG_TIMEOUT_EN (armed-state timeout; timeout tied 0 when undefined).
module run_trigger_ctrl #(
    parameter int LEN_W       = 4,
    parameter int CNT_W       = 8,
    parameter int HOLDOFF     = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic             arm,
    input  logic             disarm,
    input  logic             clr_count,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_rearm,
    output logic             armed,
    output logic             busy,
    output logic             trig,
    output logic [LEN_W-1:0] run_cnt,
    output logic [CNT_W-1:0] trig_count,
    output logic             timeout
);

    // Holdoff counter only needs to hold HOLDOFF-1.
    localparam int HO_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    // Reject configurations the sequencing cannot honour.
    if (HOLDOFF < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("run_trigger_ctrl: HOLDOFF and TIMEOUT_CYC must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_HOLDOFF = 2'd2
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic             rearm_q;
    logic [HO_W-1:0]  ho_cnt;

    logic [LEN_W-1:0] len_m1;
    logic             fire;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_inc;
    logic             to_hit;

    assign len_m1 = len_q - LEN_W'(1);

    // A trigger needs the final 1 of the run sampled this edge; disarm suppresses it.
    assign fire = (state == S_ARMED) && in && (run_cnt == len_m1) && !disarm;

    // Clear is applied before the increment so a coincident trigger leaves the count at 1.
    assign cnt_base = clr_count ? '0 : trig_count;
    assign cnt_inc  = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);

`ifdef RUN_TRIG_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TO_W-1:0] to_cnt;

    // Timeout loses to both disarm and a same-edge trigger.
    assign to_hit = (state == S_ARMED) && (to_cnt == TO_W'(TIMEOUT_CYC - 1)) && !disarm && !fire;

    // Held at 0 outside ARMED, so every entry to ARMED starts a fresh window.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (state == S_ARMED && !fire && !disarm && !to_hit) begin
            to_cnt <= to_cnt + TO_W'(1);
        end else begin
            to_cnt <= '0;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            armed      <= 1'b0;
            busy       <= 1'b0;
            trig       <= 1'b0;
            run_cnt    <= '0;
            trig_count <= '0;
            timeout    <= 1'b0;
            len_q      <= '0;
            rearm_q    <= 1'b0;
            ho_cnt     <= '0;
        end else begin
            trig       <= fire;
            timeout    <= to_hit;
            trig_count <= fire ? cnt_inc : cnt_base;

            if (disarm) begin
                state   <= S_IDLE;
                armed   <= 1'b0;
                busy    <= 1'b0;
                run_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (arm) begin
                            len_q   <= (cfg_len == '0) ? LEN_W'(1) : cfg_len;
                            rearm_q <= cfg_rearm;
                            state   <= S_ARMED;
                            armed   <= 1'b1;
                            busy    <= 1'b1;
                            run_cnt <= '0;
                        end
                    end
                    S_ARMED: begin
                        if (fire) begin
                            run_cnt <= '0;
                            ho_cnt  <= HO_W'(HOLDOFF - 1);
                            state   <= S_HOLDOFF;
                            armed   <= 1'b0;
                        end else if (to_hit) begin
                            run_cnt <= '0;
                            state   <= S_IDLE;
                            armed   <= 1'b0;
                            busy    <= 1'b0;
                        end else if (in) begin
                            run_cnt <= run_cnt + LEN_W'(1);
                        end else begin
                            run_cnt <= '0;
                        end
                    end
                    S_HOLDOFF: begin
                        // Entered at HOLDOFF-1 and leaves on the edge that sees 0:
                        // exactly HOLDOFF cycles spent here.
                        if (ho_cnt == '0) begin
                            if (rearm_q) begin
                                state <= S_ARMED;
                                armed <= 1'b1;
                            end else begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            ho_cnt <= ho_cnt - HO_W'(1);
                        end
                    end
                    default: begin
                        state   <= S_IDLE;
                        armed   <= 1'b0;
                        busy    <= 1'b0;
                        run_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_run_trigger_ctrl.sv
`timescale 1ns/1ps
module tb_run_trigger_ctrl;

    localparam int LEN_W       = 4;
    localparam int CNT_W       = 8;
    localparam int HOLDOFF     = 4;
    localparam int TIMEOUT_CYC = 255;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk       = 1'b0;
    logic             reset     = 1'b1;
    logic             din       = 1'b0;
    logic             arm       = 1'b0;
    logic             disarm    = 1'b0;
    logic             clr_count = 1'b0;
    logic [LEN_W-1:0] cfg_len   = '0;
    logic             cfg_rearm = 1'b0;
    logic             armed, busy, trig, timeout;
    logic [LEN_W-1:0] run_cnt;
    logic [CNT_W-1:0] trig_count;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    always #5 clk = ~clk;

    run_trigger_ctrl #(
        .LEN_W(LEN_W), .CNT_W(CNT_W), .HOLDOFF(HOLDOFF), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .reset(reset), .in(din), .arm(arm), .disarm(disarm),
        .clr_count(clr_count), .cfg_len(cfg_len), .cfg_rearm(cfg_rearm),
        .armed(armed), .busy(busy), .trig(trig), .run_cnt(run_cnt),
        .trig_count(trig_count), .timeout(timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 = idle, 1 = watching for a run, 2 = holdoff.
    // m_run is the length of the current run of 1s including this sample.
    int m_mode, m_len, m_run, m_cnt, m_hold, m_age;
    bit m_rearm, m_trig, m_to;

    always @(posedge clk) begin
        if (reset) begin
            m_mode = 0; m_len = 0; m_run = 0; m_cnt = 0; m_hold = 0; m_age = 0;
            m_rearm = 0; m_trig = 0; m_to = 0;
        end else begin
            m_trig = 0;
            m_to   = 0;
            if (clr_count) m_cnt = 0;
            if (disarm) begin
                m_mode = 0;
                m_run  = 0;
            end else if (m_mode == 0) begin
                if (arm) begin
                    m_len   = (cfg_len == 0) ? 1 : int'(cfg_len);
                    m_rearm = cfg_rearm;
                    m_mode  = 1;
                    m_run   = 0;
                    m_age   = 0;
                end
            end else if (m_mode == 1) begin
                m_run = din ? m_run + 1 : 0;
                m_age = m_age + 1;
                if (m_run == m_len) begin
                    m_trig = 1;
                    if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
                    m_run  = 0;
                    m_mode = 2;
                    m_hold = HOLDOFF;
                end
`ifdef RUN_TRIG_TIMEOUT_EN
                else if (m_age == TIMEOUT_CYC) begin
                    m_to   = 1;
                    m_mode = 0;
                    m_run  = 0;
                end
`endif
            end else begin
                m_hold = m_hold - 1;
                if (m_hold == 0) begin
                    m_mode = m_rearm ? 1 : 0;
                    m_age  = 0;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("armed",      armed,      32'(m_mode == 1));
            check("busy",       busy,       32'(m_mode != 0));
            check("trig",       trig,       32'(m_trig));
            check("run_cnt",    run_cnt,    32'(m_run));
            check("trig_count", trig_count, 32'(m_cnt));
            check("timeout",    timeout,    32'(m_to));
        end
    end

    // Apply inputs, let one edge pass, return 1 ns later with outputs settled.
    task automatic tick(input logic i, input logic a = 1'b0, input logic d = 1'b0, input logic c = 1'b0);
        din = i; arm = a; disarm = d; clr_count = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int to_pulses;

        // Reset
        reset = 1'b1;
        tick(0);
        tick(0);
        reset = 1'b0;
        chk_en = 1;
        check("rst_armed", armed, 0);
        check("rst_busy", busy, 0);
        check("rst_trig", trig, 0);
        check("rst_run_cnt", run_cnt, 0);
        check("rst_trig_count", trig_count, 0);
        check("rst_timeout", timeout, 0);

        // 1: len 3 single-shot, in = 1,1,0,1,1,1
        cfg_len = 4'd3; cfg_rearm = 1'b0;
        tick(0, 1);
        check("t1_armed", armed, 1);
        tick(1); check("t1_run1", run_cnt, 1);
        tick(1); check("t1_run2", run_cnt, 2);
        tick(0); check("t1_run0", run_cnt, 0);
        tick(1); check("t1_run1b", run_cnt, 1);
        tick(1); check("t1_run2b", run_cnt, 2); check("t1_notrig", trig, 0);
        tick(1); check("t1_trig", trig, 1); check("t1_count", trig_count, 1);
        tick(0); tick(0); tick(0);
        check("t1_hold_busy", busy, 1);
        tick(0);
        check("t1_idle_busy", busy, 0);
        check("t1_idle_armed", armed, 0);

        // 2: len 2 continuous, in held 1 for 20 cycles (arm cycle included)
        tick(0, 0, 0, 1);
        check("t2_cleared", trig_count, 0);
        cfg_len = 4'd2; cfg_rearm = 1'b1;
        tick(1, 1);
        for (int k = 1; k <= 19; k++) begin
            tick(1);
            if (k == 2) check("t2_trig_k2", trig, 1);
            if (k == 7) check("t2_notrig_k7", trig, 0);
            if (k == 8) check("t2_trig_k8", trig, 1);
        end
        check("t2_count", trig_count, 3);
        check("t2_busy", busy, 1);
        tick(0, 0, 1);
        check("t2_disarm_idle", busy, 0);

        // 3: len 0 acts as 1
        cfg_len = 4'd0; cfg_rearm = 1'b0;
        tick(0, 1);
        tick(1);
        check("t3_trig", trig, 1);
        check("t3_count", trig_count, 4);
        repeat (HOLDOFF) tick(0);
        check("t3_idle", busy, 0);

        // 4: len 4, arm while armed ignored, disarm suppresses trigger
        cfg_len = 4'd4; cfg_rearm = 1'b0;
        tick(0, 1);
        tick(1); tick(1);
        cfg_len = 4'd1;
        tick(1, 1);
        check("t4_rearm_ignored_run", run_cnt, 3);
        check("t4_rearm_ignored_trig", trig, 0);
        tick(1, 0, 1);
        check("t4_trig_suppressed", trig, 0);
        check("t4_armed", armed, 0);
        check("t4_busy", busy, 0);
        check("t4_count_kept", trig_count, 4);

        // 5: saturation, then clear coincident with a trigger
        tick(0, 0, 0, 1);
        cfg_len = 4'd1; cfg_rearm = 1'b1;
        tick(1, 1);
        repeat (1300) tick(1);
        check("t5_saturated", trig_count, CNT_MAX);
        seen = 0;
        for (int k = 0; k < 8 && seen == 0; k++) begin
            tick(1);
            if (trig === 1'b1) seen = 1;
        end
        check("t5_trig_at_max", seen, 1);
        check("t5_still_max", trig_count, CNT_MAX);
        seen = 0;
        for (int k = 0; k < 8 && seen == 0; k++) begin
            tick(1);
            if (armed === 1'b1) seen = 1;
        end
        check("t5_rearmed", seen, 1);
        tick(1, 0, 0, 1);
        check("t5_clr_trig", trig, 1);
        check("t5_clr_count", trig_count, 1);
        // reset in the middle of holdoff
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t5_rst_trig", trig, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_count", trig_count, 0);

        // 6: armed with in held 0
        cfg_len = 4'd3; cfg_rearm = 1'b0;
        tick(0, 1);
        to_pulses = 0;
        repeat (300) begin
            tick(0);
            if (timeout === 1'b1) to_pulses++;
        end
`ifdef RUN_TRIG_TIMEOUT_EN
        check("t6_timeout_pulses", to_pulses, 1);
        check("t6_armed", armed, 0);
`else
        check("t6_timeout_pulses", to_pulses, 0);
        check("t6_armed", armed, 1);
`endif
        tick(0, 0, 1);
        check("t6_disarm", busy, 0);

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
